// File: rtl/select_round_clip_lane.sv
// One channel of the round / part-select / clip pipeline.
// Stage 1 holds the exact rounded sum; stage 2 holds the selected or clipped output.
module select_round_clip_lane #(
    parameter int WIDTH_IN  = 31,
    parameter int WIDTH_OUT = 24,
    parameter int IW        = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stb,
    input  logic [IW-1:0]        idx,
    input  logic                 round_en,
    input  logic [WIDTH_IN-1:0]  sample,
    input  logic                 valid,
    input  logic [IW-1:0]        idx_s1,
    output logic [WIDTH_OUT-1:0] sample_out,
    output logic                 ovf
);
    localparam int SW = WIDTH_IN + 1;
    localparam logic [SW-1:0] ONE = SW'(1);

    logic [SW-1:0]        rnd;
    logic [SW-1:0]        sum;
    logic [SW-1:0]        sum_next;
    logic signed [SW-1:0] shifted;
    logic [SW-WIDTH_OUT:0] top_bits;
    logic                 overflow;
    logic [WIDTH_OUT-1:0] clip_val;

    assign rnd = (round_en && idx != '0) ? (ONE << (idx - IW'(1))) : '0;
    assign sum_next = {sample[WIDTH_IN-1], sample} + rnd;

    // Arithmetic shift keeps sign copies above the field, so the
    // bits above the output MSB must all match for the value to fit.
    assign shifted  = $signed(sum) >>> idx_s1;
    assign top_bits = shifted[SW-1:WIDTH_OUT-1];
    assign overflow = !((&top_bits) || (~|top_bits));
    assign clip_val = sum[SW-1] ? {1'b1, {(WIDTH_OUT-1){1'b0}}}
                                : {1'b0, {(WIDTH_OUT-1){1'b1}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (stb) begin
            sum <= sum_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_out <= '0;
            ovf        <= 1'b0;
        end else if (valid) begin
            sample_out <= overflow ? clip_val : shifted[WIDTH_OUT-1:0];
            ovf        <= overflow;
        end
    end
endmodule

// File: rtl/variable_part_select_round_clip.sv
// Multi-channel pipelined round / variable part-select / saturate stage.
// Owns the strobe and index pipeline plus the saturating overflow counter.
module variable_part_select_round_clip #(
    parameter int WIDTH_IN    = 31,
    parameter int WIDTH_OUT   = 24,
    parameter int INDEX_WIDTH = 3,
    parameter int NCHAN       = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic [INDEX_WIDTH-1:0]     lowidx,
    input  logic                       round_en,
    input  logic                       stb_in,
    input  logic [NCHAN*WIDTH_IN-1:0]  sample_in,
    output logic                       stb_out,
    output logic [NCHAN*WIDTH_OUT-1:0] sample_out,
    output logic [NCHAN-1:0]           ovf_out,
    output logic [CNT_WIDTH-1:0]       ovf_count
);
    localparam int unsigned MAX_IDX = WIDTH_IN - WIDTH_OUT;
    localparam int IW = (MAX_IDX < 1) ? 1 : $clog2(MAX_IDX + 1);

    generate
        if (WIDTH_OUT >= WIDTH_IN || NCHAN < 1) begin : g_illegal
            $error("variable_part_select_round_clip: illegal WIDTH_OUT/NCHAN");
        end
    endgenerate

    logic [31:0]   lowidx_ext;
    logic [IW-1:0] idx_eff;
    logic [IW-1:0] idx_s1;
    logic          valid_s1;

    assign lowidx_ext = 32'(lowidx);
    assign idx_eff = (lowidx_ext > MAX_IDX) ? IW'(MAX_IDX) : IW'(lowidx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_s1 <= 1'b0;
            idx_s1   <= '0;
            stb_out  <= 1'b0;
        end else begin
            valid_s1 <= stb_in;
            stb_out  <= valid_s1;
            if (stb_in) begin
                idx_s1 <= idx_eff;
            end
        end
    end

    for (genvar ch = 0; ch < NCHAN; ch++) begin : g_lane
        select_round_clip_lane #(
            .WIDTH_IN  (WIDTH_IN),
            .WIDTH_OUT (WIDTH_OUT),
            .IW        (IW)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .stb        (stb_in),
            .idx        (idx_eff),
            .round_en   (round_en),
            .sample     (sample_in[ch*WIDTH_IN +: WIDTH_IN]),
            .valid      (valid_s1),
            .idx_s1     (idx_s1),
            .sample_out (sample_out[ch*WIDTH_OUT +: WIDTH_OUT]),
            .ovf        (ovf_out[ch])
        );
    end

    // Counts the output sample presented this cycle; clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (clear) begin
            ovf_count <= '0;
        end else if (stb_out && (|ovf_out) && (ovf_count != '1)) begin
            ovf_count <= ovf_count + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_variable_part_select_round_clip.sv
// Directed + random bench with an arithmetic reference model.
module tb_variable_part_select_round_clip;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic [2:0]  lowidx = '0;
    logic        round_en = 1'b0;
    logic        stb_in = 1'b0;
    logic [61:0] sample_in = '0;
    logic        stb_out;
    logic [47:0] sample_out;
    logic [1:0]  ovf_out;
    logic [15:0] ovf_count;
    logic        stb_out4;
    logic [47:0] sample_out4;
    logic [1:0]  ovf_out4;
    logic [3:0]  ovf_count4;

    always #5 clk = ~clk;

    variable_part_select_round_clip dut (
        .clk(clk), .rst(rst), .clear(clear), .lowidx(lowidx),
        .round_en(round_en), .stb_in(stb_in), .sample_in(sample_in),
        .stb_out(stb_out), .sample_out(sample_out),
        .ovf_out(ovf_out), .ovf_count(ovf_count)
    );

    variable_part_select_round_clip #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .clear(clear), .lowidx(lowidx),
        .round_en(round_en), .stb_in(stb_in), .sample_in(sample_in),
        .stb_out(stb_out4), .sample_out(sample_out4),
        .ovf_out(ovf_out4), .ovf_count(ovf_count4)
    );

    typedef struct {
        int          due;
        logic [23:0] o0;
        logic [23:0] o1;
        logic [1:0]  ov;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic        e_stb = 0;
    logic [23:0] e_o0 = 0;
    logic [23:0] e_o1 = 0;
    logic [1:0]  e_ov = 0;
    int          e_cnt = 0;
    int          e_cnt4 = 0;
    logic        pend = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sx31(input logic [30:0] x);
        return x[30] ? longint'(x) - (longint'(1) << 31) : longint'(x);
    endfunction

    // Round, divide by 2^idx (floor), then saturate to 24-bit signed.
    task automatic model(input logic [30:0] s, input int li, input bit rnd,
                         output logic [23:0] o, output logic ov);
        int idx;
        longint v;
        longint qv;
        idx = (li > 7) ? 7 : li;
        v = sx31(s) + ((rnd && idx > 0) ? (longint'(1) << (idx - 1)) : 0);
        qv = v >>> idx;
        if (qv > longint'(8388607)) begin
            o = 24'h7FFFFF; ov = 1'b1;
        end else if (qv < -longint'(8388608)) begin
            o = 24'h800000; ov = 1'b1;
        end else begin
            o = qv[23:0]; ov = 1'b0;
        end
    endtask

    task automatic step(input bit stb, input logic [30:0] s0, input logic [30:0] s1,
                        input int li, input bit rnd, input bit clr);
        exp_t e;
        logic ov0;
        logic ov1;
        stb_in = stb;
        sample_in = {s1, s0};
        lowidx = 3'(li);
        round_en = rnd;
        clear = clr;
        model(s0, li, rnd, e.o0, ov0);
        model(s1, li, rnd, e.o1, ov1);
        e.ov = {ov1, ov0};
        @(posedge clk);
        #1;
        cyc++;
        if (clr) begin
            e_cnt = 0; e_cnt4 = 0;
        end else if (pend) begin
            if (e_cnt < 65535) e_cnt++;
            if (e_cnt4 < 15) e_cnt4++;
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            e_stb = 1; e_o0 = q[0].o0; e_o1 = q[0].o1; e_ov = q[0].ov;
            void'(q.pop_front());
        end else begin
            e_stb = 0;
        end
        pend = e_stb && (|e_ov);
        if (stb) begin
            e.due = cyc + 1;
            q.push_back(e);
        end
        chk("stb_out", 64'(stb_out), 64'(e_stb));
        chk("ch0", 64'(sample_out[23:0]), 64'(e_o0));
        chk("ch1", 64'(sample_out[47:24]), 64'(e_o1));
        chk("ovf_out", 64'(ovf_out), 64'(e_ov));
        chk("ovf_count", 64'(ovf_count), 64'(e_cnt));
        chk("ovf_count4", 64'(ovf_count4), 64'(e_cnt4));
        stb_in = 0;
        clear = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, 0);
    endtask

    task automatic pulse_reset();
        rst = 1;
        #1;
        q.delete();
        e_stb = 0; e_o0 = 0; e_o1 = 0; e_ov = 0;
        e_cnt = 0; e_cnt4 = 0; pend = 0;
        chk("rst_stb", 64'(stb_out), 64'(0));
        chk("rst_sample", 64'(sample_out), 64'(0));
        chk("rst_ovf", 64'(ovf_out), 64'(0));
        chk("rst_cnt", 64'(ovf_count), 64'(0));
        chk("rst_cnt4", 64'(ovf_count4), 64'(0));
        @(posedge clk);
        #2;
        cyc++;
        stb_in = 0;
        rst = 0;
    endtask

    initial begin
        logic [30:0] r0;
        logic [30:0] r1;
        int sel;
        rst = 1;
        #2;
        chk("reset_stb", 64'(stb_out), 64'(0));
        chk("reset_sample", 64'(sample_out), 64'(0));
        chk("reset_cnt", 64'(ovf_count), 64'(0));
        @(posedge clk);
        #1;
        rst = 0;
        cyc++;
        idle(2);

        step(1, 31'h0000123, 31'h7FFFFFFB, 0, 0, 0);
        idle(2);
        chk("plan_ch0", 64'(sample_out[23:0]), 64'h000123);
        chk("plan_ch1", 64'(sample_out[47:24]), 64'hFFFFFB);

        step(1, 31'd12, 31'd0, 3, 1, 0);
        step(1, 31'd12, 31'd0, 3, 0, 0);
        step(1, 31'h7FFFFFF4, 31'd0, 3, 1, 0);
        idle(2);
        chk("plan_neg_round", 64'(sample_out[23:0]), 64'hFFFFFF);

        step(1, 31'h0800000, 31'd0, 0, 0, 0);
        step(1, 31'h7F7FFFFF, 31'd0, 0, 0, 0);
        idle(3);
        chk("plan_cnt2", 64'(ovf_count), 64'd2);

        step(1, 31'h3FFFFFFF, 31'h40000000, 7, 0, 0);
        step(1, 31'h3FFFFFFF, 31'h40000000, 7, 1, 0);
        for (int i = 0; i < 8; i++)
            step(1, 31'h3FFFFFFF - 31'(i * 977), 31'h4000003F + 31'(i), i, i[0], 0);
        idle(2);

        for (int i = 0; i < 20; i++)
            step(1, 31'h3FFFFFFF, 31'h40000000, i % 3, 0, 0);
        step(0, '0, '0, 0, 0, 0);
        chk("sat4", 64'(ovf_count4), 64'd15);
        step(0, '0, '0, 0, 0, 1);
        chk("clear_prio", 64'(ovf_count4), 64'd0);
        idle(2);

        step(1, 31'd1000, 31'd77, 2, 1, 0);
        stb_in = 1;
        sample_in = {31'd5, 31'd6};
        pulse_reset();
        idle(3);
        step(1, 31'd40, 31'h7FFFFFD8, 2, 0, 0);
        step(0, '0, '0, 0, 0, 0);
        chk("post_rst_val", 64'(sample_out[23:0]), 64'd10);
        idle(1);

        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 3);
            r0 = 31'($urandom);
            r1 = 31'($urandom);
            if (sel == 1) r0 = 31'($urandom_range(0, 4000)) - 31'd2000;
            if (sel == 2) r1 = {r1[30], 7'(r1[30] ? 7'h7F : 7'h00), r1[22:0]};
            step($urandom_range(0, 3) != 0, r0, r1, $urandom_range(0, 7),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 40) == 0);
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
